// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the RV32 multi-cycle sequencer: FSM state encoding,
// the opcode set the sequencer recognises, and the reset-time NOP encoding.
package core_seq_ctrl_pkg;

    // Sequencer states. Three-bit encoding; values 6 and 7 are unreachable.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT_I = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } seq_state_t;

    // Major opcodes the sequencer knows how to retire.
    localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    // ADDI x0,x0,0 -- loaded into the instruction register on reset so decode
    // always sees a harmless encoding before the first fetch completes.
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

    // Width of a fixed-length RV32 instruction in bytes, used for PC stepping.
    localparam logic [31:0] INSN_BYTES = 32'd4;

    // True for the opcodes the sequencer can carry through EXEC and WB.
    function automatic logic opcode_supported(input logic [6:0] op);
        return (op == OPCODE_R_TYPE) || (op == OPCODE_I_TYPE) ||
               (op == OPCODE_LUI)    || (op == OPCODE_JAL);
    endfunction

    // True for ALU-class opcodes that always write a destination register,
    // independent of what decode reports on its writeback flag.
    function automatic logic opcode_alu_writes(input logic [6:0] op);
        return (op == OPCODE_R_TYPE) || (op == OPCODE_I_TYPE);
    endfunction

endpackage

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the RV32 core. Owns the PC, fetches each
// instruction over a valid/ready request plus a response-valid return path,
// holds the instruction register that feeds decode, then steps through
// DECODE, EXEC and WB. Unsupported opcodes either park the core in a sticky
// TRAP state or are retired as a NOP, selected by TRAP_EN.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          TRAP_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    // instruction-memory request channel
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    // instruction-memory response channel
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    // decode interface (decode is combinational from ir)
    output logic [31:0] ir,
    input  logic [6:0]  dec_opcode,
    input  logic        dec_writeback,
    input  logic [31:0] dec_imm,
    // status / strobes
    output logic [31:0] pc,
    output logic        alu_en,
    output logic        rf_we,
    output logic        retire,
    output logic [31:0] instret,
    output logic        trap
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    seq_state_t  state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] ir_q,      ir_d;
    logic [31:0] instret_q, instret_d;
    logic        trap_q,    trap_d;

    // Strobes are registered: each *_d describes the state being entered,
    // so every strobe is a pure function of the current state (plus the
    // writeback decision captured on the way into WB).
    logic        req_valid_q, req_valid_d;
    logic        alu_en_q,    alu_en_d;
    logic        rf_we_q,     rf_we_d;
    logic        retire_q,    retire_d;

    // ------------------------------------------------------------------
    // Opcode classification and next-PC candidates
    // ------------------------------------------------------------------
    logic        op_supported;
    logic        op_alu_writes;
    logic        op_is_jal;
    logic        take_trap;
    logic [31:0] pc_seq;
    logic [31:0] pc_jump;

    assign op_supported  = opcode_supported(dec_opcode);
    assign op_alu_writes = opcode_alu_writes(dec_opcode);
    assign op_is_jal     = (dec_opcode == OPCODE_JAL);
    assign take_trap     = !op_supported && TRAP_EN;

    // Both additions wrap modulo 2^32; no alignment check on the target.
    assign pc_seq  = pc_q + INSN_BYTES;
    assign pc_jump = pc_q + dec_imm;

    // Next-state, datapath and strobe selection for every state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        instret_d   = instret_q;
        trap_d      = trap_q;
        req_valid_d = 1'b0;
        alu_en_d    = 1'b0;
        rf_we_d     = 1'b0;
        retire_d    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Request is always valid here, so ready alone completes the
                // handshake. Address is pc_q, which cannot change in FETCH.
                if (imem_req_ready) begin
                    state_d = ST_WAIT_I;
                end else begin
                    req_valid_d = 1'b1;
                end
            end

            ST_WAIT_I: begin
                // The response channel is only looked at in this state; any
                // response arriving elsewhere is dropped on the floor.
                if (imem_rsp_valid) begin
                    ir_d    = imem_rsp_data;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // One settle cycle for the combinational decoder on ir.
                if (take_trap) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                end else begin
                    state_d  = ST_EXEC;
                    alu_en_d = 1'b1;
                end
            end

            ST_EXEC: begin
                // Decide the register-file write while ir is still stable so
                // the WB strobe comes straight out of a flop. Unsupported
                // opcodes retired as NOPs never write.
                state_d  = ST_WB;
                retire_d = 1'b1;
                rf_we_d  = op_supported && (dec_writeback || op_alu_writes);
            end

            ST_WB: begin
                state_d     = ST_FETCH;
                req_valid_d = 1'b1;
                instret_d   = instret_q + 32'd1;
                pc_d        = op_is_jal ? pc_jump : pc_seq;
            end

            ST_TRAP: begin
                // Parked until reset; everything else stays frozen.
                trap_d = 1'b1;
            end

            default: begin
                // Unreachable encodings are treated like an illegal
                // instruction so a corrupted state never runs on silently.
                state_d = ST_TRAP;
                trap_d  = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset wins over any same-cycle handshake or retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= NOP_ENCODING;
            instret_q   <= 32'd0;
            trap_q      <= 1'b0;
            req_valid_q <= 1'b1;   // first cycle out of reset is FETCH
            alu_en_q    <= 1'b0;
            rf_we_q     <= 1'b0;
            retire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            instret_q   <= instret_d;
            trap_q      <= trap_d;
            req_valid_q <= req_valid_d;
            alu_en_q    <= alu_en_d;
            rf_we_q     <= rf_we_d;
            retire_q    <= retire_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes are held low for as long as reset is asserted so an
    // instruction interrupted by reset never writes back or retires, and no
    // fetch is requested while the core is being reset.
    // ------------------------------------------------------------------
    assign imem_req_valid = req_valid_q & ~rst;
    assign alu_en         = alu_en_q    & ~rst;
    assign rf_we          = rf_we_q     & ~rst;
    assign retire         = retire_q    & ~rst;

    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;
    assign ir             = ir_q;
    assign instret        = instret_q;
    assign trap           = trap_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl. Two instances run in lockstep from the same
// imem stimulus: dut_a traps on unsupported opcodes, dut_b retires them as
// NOPs. Each instance has its own small decoder built from its ir. Retired
// instructions of dut_a are checked against a scoreboard queue filled when
// the fetch handshake is driven.
module tb_core_seq_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;

    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr_a,  req_addr_b;
    logic [31:0] ir_a, ir_b, pc_a, pc_b, instret_a, instret_b;
    logic        alu_en_a, alu_en_b, rf_we_a, rf_we_b, retire_a, retire_b, trap_a, trap_b;
    logic [6:0]  dec_op_a, dec_op_b;
    logic        dec_wb_a, dec_wb_b;
    logic [31:0] dec_imm_a, dec_imm_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] pc_model      = 32'h0;
    logic [31:0] instret_model = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [31:0] instret;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    typedef struct {
        logic        do_rst;
        logic [31:0] instr;
        int          rdy_d;
        int          rsp_d;
        logic        exp_we;
        logic [31:0] exp_next_pc;
        int          exp_lat;
    } vec_t;
    vec_t tbl[7];

    // Reference decoder: only LUI/JAL raise writeback, so the ALU-class term
    // of the write-enable is exercised separately from the decode flag.
    function automatic logic wb_of(input logic [6:0] op);
        return (op == OP_LUI) || (op == OP_JAL);
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i);
        if (i[6:0] == OP_JAL)
            return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    assign dec_op_a  = ir_a[6:0];
    assign dec_wb_a  = wb_of(ir_a[6:0]);
    assign dec_imm_a = imm_of(ir_a);
    assign dec_op_b  = ir_b[6:0];
    assign dec_wb_b  = wb_of(ir_b[6:0]);
    assign dec_imm_b = imm_of(ir_b);

    core_seq_ctrl #(.RESET_PC(32'h0000_0000), .TRAP_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid_a), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_a),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ir(ir_a), .dec_opcode(dec_op_a), .dec_writeback(dec_wb_a), .dec_imm(dec_imm_a),
        .pc(pc_a), .alu_en(alu_en_a), .rf_we(rf_we_a), .retire(retire_a),
        .instret(instret_a), .trap(trap_a)
    );

    core_seq_ctrl #(.RESET_PC(32'h0000_0000), .TRAP_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid_b), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_b),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ir(ir_b), .dec_opcode(dec_op_b), .dec_writeback(dec_wb_b), .dec_imm(dec_imm_b),
        .pc(pc_b), .alu_en(alu_en_b), .rf_we(rf_we_b), .retire(retire_b),
        .instret(instret_b), .trap(trap_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: one line per retired instruction of dut_a.
    always @(negedge clk) begin
        if (!rst && retire_a) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire actual pc=%h required no retire", pc_a);
            end else begin
                sb_e = sb_q.pop_front();
                if (rf_we_a !== sb_e.we || pc_a !== sb_e.pc || instret_a !== sb_e.instret) begin
                    errors++;
                    $display("FAIL retire_record actual we=%b pc=%h instret=%h required we=%b pc=%h instret=%h",
                             rf_we_a, pc_a, instret_a, sb_e.we, sb_e.pc, sb_e.instret);
                end
                $display("txn retire pc=%h ir=%h rf_we=%b instret=%h", pc_a, ir_a, rf_we_a, instret_a);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_strobes_low", {28'd0, req_valid_a, alu_en_a, rf_we_a, retire_a}, 32'd0);
        rst = 1'b0;
        pc_model = 32'h0;
        instret_model = 32'h0;
        sb_q.delete();
        #1;
    endtask

    // Drive one fetch: ready held low rdy_d cycles (junk responses offered
    // meanwhile), response returned rsp_d cycles into WAIT_I. Returns in DECODE.
    task automatic issue(input logic [31:0] instr, input int rdy_d, input int rsp_d,
                         input logic exp_ret, input logic exp_we, output int c0);
        int n;
        logic stable;
        n = 0;
        while (!req_valid_a && n < 20) begin @(negedge clk); n++; end
        chk("fetch_req_valid", {31'd0, req_valid_a}, 32'd1);
        chk("fetch_addr", req_addr_a, pc_model);
        c0 = cyc;
        stable = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        imem_req_ready = (rdy_d == 0);
        for (int i = 0; i < rdy_d; i++) begin
            @(negedge clk);
            if (req_addr_a !== pc_model || req_valid_a !== 1'b1) stable = 1'b0;
        end
        if (rdy_d > 0) chk("stall_addr_stable", {31'd0, stable}, 32'd1);
        imem_req_ready = 1'b1;
        if (exp_ret) sb_q.push_back('{pc_model, exp_we, instret_model});
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < rsp_d; i++) @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    task automatic finish_retire(input int c0, input int exp_lat, input logic [31:0] exp_next_pc);
        int n;
        int alu;
        n = 0;
        alu = 0;
        while (!retire_a && n < 12) begin
            if (alu_en_a) alu++;
            @(negedge clk);
            n++;
        end
        chk("retire_seen", {31'd0, retire_a}, 32'd1);
        chk("latency", 32'(cyc - c0 + 1), 32'(exp_lat));
        chk("alu_en_pulses", 32'(alu), 32'd1);
        @(negedge clk);
        chk("next_pc", pc_a, exp_next_pc);
        chk("next_req_addr", req_addr_a, exp_next_pc);
        chk("instret", instret_a, instret_model + 32'd1);
        pc_model = exp_next_pc;
        instret_model = instret_model + 32'd1;
    endtask

    task automatic run_vec(input vec_t v);
        int c0;
        if (v.do_rst) do_reset();
        issue(v.instr, v.rdy_d, v.rsp_d, 1'b1, v.exp_we, c0);
        finish_retire(c0, v.exp_lat, v.exp_next_pc);
    endtask

    initial begin
        int c0;
        int n;
        int ra, rb, aa;
        logic web;
        vec_t v;

        //            rst   instr                          rdy rsp we    next pc         lat
        tbl[0] = '{1'b1, 32'h0050_0093,                 0,  0, 1'b1, 32'h0000_0004,  5};  // ADDI x1,x0,5
        tbl[1] = '{1'b0, 32'h0010_8133,                 3,  2, 1'b1, 32'h0000_0008, 10};  // ADD x2,x1,x1
        tbl[2] = '{1'b0, enc_jal(32'd16, 5'd1),         0,  0, 1'b1, 32'h0000_0018,  5};  // JAL +16 at 8
        tbl[3] = '{1'b0, 32'h1234_51B7,                 1,  0, 1'b1, 32'h0000_001C,  6};  // LUI x3
        tbl[4] = '{1'b0, 32'h0010_0093,                 2,  1, 1'b1, 32'h0000_0020,  8};  // ADDI x1,x0,1
        tbl[5] = '{1'b1, 32'h0050_0093,                 0,  0, 1'b1, 32'h0000_0004,  5};  // ADDI after reset
        tbl[6] = '{1'b0, enc_jal(32'hFFFF_FFF8, 5'd1),  0,  0, 1'b1, 32'hFFFF_FFFC,  5};  // JAL -8 at 4

        // Reset state
        do_reset();
        chk("reset_pc", pc_a, 32'h0);
        chk("reset_ir", ir_a, 32'h0000_0013);
        chk("reset_instret", instret_a, 32'h0);
        chk("reset_trap", {31'd0, trap_a}, 32'd0);
        chk("reset_req_valid", {31'd0, req_valid_a}, 32'd1);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Reset while in EXEC: instruction dropped, back to FETCH at reset PC.
        issue(32'h0050_0093, 0, 0, 1'b0, 1'b0, c0);
        @(negedge clk);
        chk("exec_alu_en", {31'd0, alu_en_a}, 32'd1);
        rst = 1'b1;
        #1;
        chk("exec_rst_strobes", {29'd0, alu_en_a, rf_we_a, retire_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("exec_rst_req_valid", {31'd0, req_valid_a}, 32'd1);
        chk("exec_rst_addr", req_addr_a, 32'h0);
        chk("exec_rst_instret", instret_a, 32'h0);
        pc_model = 32'h0;
        instret_model = 32'h0;
        sb_q.delete();

        v = '{1'b0, 32'h0050_0093, 0, 0, 1'b1, 32'h0000_0004, 5};
        run_vec(v);

        // Reset in the same cycle as a fetch handshake: handshake is lost.
        n = 0;
        while (!req_valid_a && n < 20) begin @(negedge clk); n++; end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("hs_rst_req_valid", {31'd0, req_valid_a}, 32'd1);
        chk("hs_rst_addr", req_addr_a, 32'h0);
        chk("hs_rst_instret", instret_a, 32'h0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("hs_rst_still_fetch", {31'd0, req_valid_a}, 32'd1);
        chk("hs_rst_ir", ir_a, 32'h0000_0013);
        pc_model = 32'h0;
        instret_model = 32'h0;
        sb_q.delete();

        // instret wrap: preload all-ones while parked in FETCH, retire one ADD.
        force dut_a.instret_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut_a.instret_q;
        @(negedge clk);
        chk("instret_preload", instret_a, 32'hFFFF_FFFF);
        instret_model = 32'hFFFF_FFFF;
        v = '{1'b0, 32'h0010_8133, 0, 0, 1'b1, 32'h0000_0004, 5};
        run_vec(v);

        // Load opcode: dut_a traps, dut_b retires it as a non-writing NOP.
        issue(32'h0000_A283, 0, 0, 1'b0, 1'b0, c0);
        ra = 0; rb = 0; aa = 0; web = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (retire_a) ra++;
            if (alu_en_a) aa++;
            if (retire_b) begin rb++; web = rf_we_b; end
        end
        chk("trap_flag", {31'd0, trap_a}, 32'd1);
        chk("trap_no_retire", 32'(ra), 32'd0);
        chk("trap_no_alu", 32'(aa), 32'd0);
        chk("trap_req_valid", {31'd0, req_valid_a}, 32'd0);
        chk("trap_pc_frozen", pc_a, 32'h0000_0004);
        chk("trap_instret_frozen", instret_a, 32'h0);
        chk("nop_retire_count", 32'(rb), 32'd1);
        chk("nop_rf_we", {31'd0, web}, 32'd0);
        chk("nop_next_pc", req_addr_b, 32'h0000_0008);
        chk("nop_req_valid", {31'd0, req_valid_b}, 32'd1);
        chk("nop_trap", {31'd0, trap_b}, 32'd0);
        chk("nop_instret", instret_b, 32'd2);
        $display("txn trap pc=%h ir=%h (nop path pc now %h)", pc_a, ir_a, pc_b);

        do_reset();
        chk("trap_cleared", {31'd0, trap_a}, 32'd0);
        chk("trap_rst_pc", pc_a, 32'h0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
